// File: rtl/flash_reader_if.sv
// CPU-side flash-read port: level request with address, and the returned byte with its ready flag.
interface flash_reader_if;
    logic        enable;
    logic [10:0] addr;
    logic [7:0]  data_out;
    logic        data_ready;

    modport master (output enable, output addr, input data_out, input data_ready);
    modport slave  (input enable, input addr, output data_out, output data_ready);
endinterface

// File: rtl/flash_reader.sv
// SPI NOR flash byte reader: issues READ (0x03) + 24-bit address, shifts in one byte (SPI mode 0).
// Optional one-entry read cache enabled by defining FLASH_READER_CACHE_EN.
module flash_reader #(
    parameter int unsigned CLK_DIV        = 2,
    parameter logic [23:0] BASE_ADDR      = 24'h000000,
    parameter logic [15:0] STARTUP_CYCLES = 16'd1000
) (
    input  logic          clk,
    input  logic          reset,
    flash_reader_if.slave bus,
    output logic          flash_clk,
    output logic          flash_cs_n,
    output logic          flash_mosi,
    input  logic          flash_miso
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] startup_cnt_r, startup_cnt_s;
    logic [15:0] div_cnt_r, div_cnt_s;
    logic [5:0]  pulse_r, pulse_s;
    logic [30:0] shift_r, shift_s;
    logic [7:0]  rx_r, rx_s;
    logic        sck_r, sck_s;
    logic        cs_n_r, cs_n_s;
    logic        mosi_r, mosi_s;
    logic [7:0]  data_out_r, data_out_s;
    logic        data_ready_r, data_ready_s;

    logic [23:0] addr_sum_s;
    logic [31:0] cmd_word_s;
    logic        tick_s;
    logic        last_s;
    logic        hit_s;

    assign addr_sum_s = BASE_ADDR + {13'd0, bus.addr};
    assign cmd_word_s = {8'h03, addr_sum_s};
    assign tick_s     = (div_cnt_r == 16'(CLK_DIV - 32'd1));
    assign last_s     = tick_s && sck_r && (pulse_r == 6'd39);

`ifdef FLASH_READER_CACHE_EN
    // data_out_r always holds the byte of the cached address, so only the tag is stored.
    logic        cache_valid_r, cache_valid_s;
    logic [10:0] cache_addr_r, cache_addr_s;
    assign hit_s = cache_valid_r && (cache_addr_r == bus.addr);
`else
    assign hit_s = 1'b0;
`endif

    assign flash_clk       = sck_r;
    assign flash_cs_n      = cs_n_r;
    assign flash_mosi      = mosi_r;
    assign bus.data_out    = data_out_r;
    assign bus.data_ready  = data_ready_r;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_STARTUP;
            startup_cnt_r <= 16'd0;
            div_cnt_r     <= 16'd0;
            pulse_r       <= 6'd0;
            shift_r       <= 31'd0;
            rx_r          <= 8'd0;
            sck_r         <= 1'b0;
            cs_n_r        <= 1'b1;
            mosi_r        <= 1'b0;
            data_out_r    <= 8'd0;
            data_ready_r  <= 1'b0;
`ifdef FLASH_READER_CACHE_EN
            cache_valid_r <= 1'b0;
            cache_addr_r  <= 11'd0;
`endif
        end else begin
            state_r       <= state_s;
            startup_cnt_r <= startup_cnt_s;
            div_cnt_r     <= div_cnt_s;
            pulse_r       <= pulse_s;
            shift_r       <= shift_s;
            rx_r          <= rx_s;
            sck_r         <= sck_s;
            cs_n_r        <= cs_n_s;
            mosi_r        <= mosi_s;
            data_out_r    <= data_out_s;
            data_ready_r  <= data_ready_s;
`ifdef FLASH_READER_CACHE_EN
            cache_valid_r <= cache_valid_s;
            cache_addr_r  <= cache_addr_s;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_STARTUP: begin
                if (({1'b0, startup_cnt_r} + 17'd1) >= {1'b0, STARTUP_CYCLES}) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STARTUP;
                end
            end
            ST_IDLE: begin
                if (bus.enable) begin
                    state_s = hit_s ? ST_DONE : ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_s = bus.enable ? ST_DONE : ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (!bus.enable) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_STARTUP;
        endcase
    end

    // Datapath and pin updates for each state
    always_comb begin
        startup_cnt_s = startup_cnt_r;
        div_cnt_s     = div_cnt_r;
        pulse_s       = pulse_r;
        shift_s       = shift_r;
        rx_s          = rx_r;
        sck_s         = sck_r;
        cs_n_s        = cs_n_r;
        mosi_s        = mosi_r;
        data_out_s    = data_out_r;
        data_ready_s  = data_ready_r;
`ifdef FLASH_READER_CACHE_EN
        cache_valid_s = cache_valid_r;
        cache_addr_s  = cache_addr_r;
`endif
        case (state_r)
            ST_STARTUP: startup_cnt_s = startup_cnt_r + 16'd1;
            ST_IDLE: begin
                if (bus.enable && hit_s) begin
                    data_ready_s = 1'b0;
                end else if (bus.enable) begin
                    data_ready_s = 1'b0;
                    cs_n_s       = 1'b0;
                    sck_s        = 1'b0;
                    mosi_s       = cmd_word_s[31];
                    shift_s      = cmd_word_s[30:0];
                    div_cnt_s    = 16'd0;
                    pulse_s      = 6'd0;
                    rx_s         = 8'd0;
`ifdef FLASH_READER_CACHE_EN
                    cache_valid_s = 1'b0;
                    cache_addr_s  = bus.addr;
`endif
                end else begin
                    data_ready_s = data_ready_r;
                end
            end
            ST_SHIFT: begin
                if (!tick_s) begin
                    div_cnt_s = div_cnt_r + 16'd1;
                end else if (!sck_r) begin
                    div_cnt_s = 16'd0;
                    sck_s     = 1'b1;
                    rx_s      = (pulse_r >= 6'd32) ? {rx_r[6:0], flash_miso} : rx_r;
                end else if (pulse_r != 6'd39) begin
                    div_cnt_s = 16'd0;
                    sck_s     = 1'b0;
                    pulse_s   = pulse_r + 6'd1;
                    shift_s   = {shift_r[29:0], 1'b0};
                    mosi_s    = (pulse_r < 6'd31) ? shift_r[30] : 1'b0;
                end else begin
                    div_cnt_s    = 16'd0;
                    sck_s        = 1'b0;
                    pulse_s      = 6'd0;
                    cs_n_s       = 1'b1;
                    mosi_s       = 1'b0;
                    data_out_s   = rx_r;
                    data_ready_s = 1'b1;
`ifdef FLASH_READER_CACHE_EN
                    cache_valid_s = 1'b1;
`endif
                end
            end
            ST_DONE: data_ready_s = 1'b1;
            default: startup_cnt_s = 16'd0;
        endcase
    end

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: behavioural SPI flash model plus a scoreboard of expected reads.
module tb_flash_reader;

    localparam int unsigned CLK_DIV = 2;
    localparam logic [23:0] BASE    = 24'hFFFFF0;
    localparam int unsigned SC      = 30;
`ifdef FLASH_READER_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] cmd;
        logic [7:0]  data;
        logic        hit;
        int          txns;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    logic flash_clk, flash_cs_n, flash_mosi;
    logic flash_miso = 1'b0;
    flash_reader_if ifc();

    flash_reader #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE), .STARTUP_CYCLES(16'(SC))) dut (
        .clk(clk), .reset(reset), .bus(ifc),
        .flash_clk(flash_clk), .flash_cs_n(flash_cs_n),
        .flash_mosi(flash_mosi), .flash_miso(flash_miso)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    sb_t sb[$];
    logic [7:0]  flash_byte = 8'h00;
    logic        cache_valid_m = 1'b0;
    logic [10:0] cache_addr_m = 11'd0;
    logic [7:0]  last_data_m = 8'd0;

    int cyc = 0, cs_fall_cyc = 0, rises = 0, falls = 0, txn_cnt = 0;
    int sck_edges = 0, stray = 0;
    logic [31:0] cmd_cap = 32'd0;
    logic cs_prev = 1'b1, sck_prev = 1'b0, dr_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash model and scoreboard consumer, sampled on the falling clk edge
    always @(negedge clk) begin
        sb_t e;
        cyc++;
        if (!flash_cs_n && cs_prev) begin
            cs_fall_cyc = cyc;
            rises = 0;
            falls = 0;
            flash_miso = 1'b0;
            txn_cnt++;
        end
        if (flash_clk != sck_prev) sck_edges++;
        if (flash_cs_n && cs_prev && (flash_clk != sck_prev)) stray++;
        if (!flash_cs_n) begin
            if (flash_clk && !sck_prev) begin
                if (rises < 32) cmd_cap = {cmd_cap[30:0], flash_mosi};
                rises++;
            end
            if (!flash_clk && sck_prev) begin
                falls++;
                if (falls >= 32 && falls <= 39) flash_miso = flash_byte[3'(39 - falls)];
            end
        end
        if (ifc.data_ready && !dr_prev) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_ready", 40'(sb.size()), 40'd1);
            end else begin
                e = sb.pop_front();
                check_eq("data_out", 40'(ifc.data_out), 40'(e.data));
                if (e.hit) begin
                    check_eq("hit_no_spi", 40'(txn_cnt), 40'(e.txns));
                end else begin
                    check_eq("cmd_addr", 40'(cmd_cap), 40'(e.cmd));
                    check_eq("sck_pulses", 40'(rises), 40'd40);
                    check_eq("latency", 40'(cyc - cs_fall_cyc), 40'(80 * CLK_DIV));
                    check_eq("cs_n_at_ready", 40'(flash_cs_n), 40'd1);
                    check_eq("one_txn", 40'(txn_cnt), 40'(e.txns + 1));
                end
            end
        end
        cs_prev  = flash_cs_n;
        sck_prev = flash_clk;
        dr_prev  = ifc.data_ready;
    end

    task automatic sb_push(input logic [10:0] a, input logic [7:0] b, input logic hit);
        sb_t e;
        e.cmd  = {8'h03, 24'(BASE + {13'd0, a})};
        e.hit  = hit;
        e.data = hit ? last_data_m : b;
        e.txns = txn_cnt;
        sb.push_back(e);
        if (!hit) begin
            cache_valid_m = 1'b1;
            cache_addr_m  = a;
            last_data_m   = b;
        end
    endtask

    task automatic start_read(input logic [10:0] a, input logic [7:0] b);
        logic hit;
        hit = CACHE_EN && cache_valid_m && (cache_addr_m == a);
        flash_byte = b;
        sb_push(a, b, hit);
        ifc.addr   = a;
        ifc.enable = 1'b1;
        @(negedge clk);
        check_eq("start_ready_low", 40'(ifc.data_ready), 40'd0);
        if (hit) begin
            check_eq("hit_cs_idle", 40'(flash_cs_n), 40'd1);
            @(negedge clk);
            check_eq("hit_ready_e2", 40'(ifc.data_ready), 40'd1);
        end else begin
            check_eq("start_cs_low", 40'(flash_cs_n), 40'd0);
            check_eq("start_mosi", 40'(flash_mosi), 40'd0);
        end
    endtask

    task automatic wait_done(input int drop_at);
        int n = 0;
        while (!ifc.data_ready && n < int'(80 * CLK_DIV + 20)) begin
            @(negedge clk);
            n++;
            if (n == drop_at) ifc.enable = 1'b0;
        end
        check_eq("done_seen", 40'(ifc.data_ready), 40'd1);
        if (ifc.enable) begin
            ifc.enable = 1'b0;
            @(negedge clk);
            check_eq("ready_hold", 40'(ifc.data_ready), 40'd1);
        end
    endtask

    task automatic do_read(input logic [10:0] a, input logic [7:0] b, input int drop_at);
        start_read(a, b);
        wait_done(drop_at);
    endtask

    initial begin
        int early;
        int snap;
        reset      = 1'b1;
        ifc.enable = 1'b1;
        ifc.addr   = 11'h123;
        repeat (3) @(negedge clk);
        check_eq("rst_cs_n", 40'(flash_cs_n), 40'd1);
        check_eq("rst_sck", 40'(flash_clk), 40'd0);
        check_eq("rst_mosi", 40'(flash_mosi), 40'd0);
        check_eq("rst_ready", 40'(ifc.data_ready), 40'd0);
        check_eq("rst_data", 40'(ifc.data_out), 40'd0);

        flash_byte = 8'hA5;
        sb_push(11'h123, 8'hA5, 1'b0);
        reset = 1'b0;
        early = 0;
        for (int k = 0; k < int'(SC); k++) begin
            @(negedge clk);
            if (!flash_cs_n) early++;
        end
        check_eq("startup_quiet", 40'(early), 40'd0);
        @(negedge clk);
        check_eq("first_start_cs", 40'(flash_cs_n), 40'd0);
        wait_done(0);

        do_read(11'h010, 8'h3C, 0);
        do_read(11'h00F, 8'h81, 0);
        do_read(11'h020, 8'h5A, 0);
        do_read(11'h020, 8'hC3, 0);
        do_read(11'h7FF, 8'h96, 20);
        do_read(11'h155, 8'h69, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)), 0);
        end

        start_read(11'h2AA, 8'hF0);
        repeat (38) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_cs_n", 40'(flash_cs_n), 40'd1);
        check_eq("midrst_sck", 40'(flash_clk), 40'd0);
        check_eq("midrst_ready", 40'(ifc.data_ready), 40'd0);
        check_eq("midrst_data", 40'(ifc.data_out), 40'd0);
        ifc.enable = 1'b0;
        sb.delete();
        cache_valid_m = 1'b0;
        @(negedge clk);
        snap = sck_edges;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (SC + 3) @(negedge clk);
        check_eq("midrst_no_sck", 40'(sck_edges), 40'(snap));
        check_eq("midrst_cs_idle", 40'(flash_cs_n), 40'd1);

        do_read(11'h020, 8'h77, 0);
        do_read(11'h020, 8'h11, 0);
        do_read(11'h400, 8'hE1, 0);
        check_eq("stray_sck", 40'(stray), 40'd0);
        check_eq("sb_drained", 40'(sb.size()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
